// File: rtl/bat_amateur_regfile.sv
// Eight-register bus file with A/B taps to the ALU and a 2-deep display queue fed by OUT.
// Drive is combinational; load, increment, queue and sticky error flags update on the rising edge.
module bat_amateur_regfile (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] REGS_INC,
  input  logic [7:0] REGS_RW,
  input  logic [7:0] REGS_EN,
  input  logic [7:0] BUS_IN,
  output logic [7:0] BUS_OUT,
  output logic       BUS_DRIVE,
  output logic [7:0] A_VAL,
  output logic [7:0] B_VAL,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  input  logic       ERR_CLR,
  output logic       BUS_CONFLICT,
  output logic       OUT_OVF
);

  localparam int OUT_IDX = 7;

  logic [7:0] regs [8];
  logic [7:0] inc_sel;
  logic [7:0] ld_sel;
  logic [7:0] drv_sel;
  logic       conflict_now;
  logic       push;
  logic       pop;
  logic       drop;
  logic [7:0] out_next;
  logic [7:0] q0;
  logic [7:0] q1;
  logic [1:0] cnt;

  function automatic logic [7:0] inc_mod256(input logic [7:0] v);
    return v + 8'd1;
  endfunction

  assign inc_sel = REGS_EN & REGS_INC;
  assign ld_sel  = REGS_EN & ~REGS_INC & REGS_RW;
  // Drivers are masked while reset is held so the bus is released immediately.
  assign drv_sel = REGS_EN & ~REGS_INC & ~REGS_RW & {8{RST}};

  // Clearing the lowest set bit leaves something only when two or more drivers exist.
  assign conflict_now = (drv_sel & (drv_sel - 8'd1)) != 8'd0;

  always_comb begin
    BUS_OUT   = 8'h00;
    BUS_DRIVE = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (drv_sel[i]) begin
        BUS_OUT   = regs[i];
        BUS_DRIVE = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (inc_sel[i])     regs[i] <= inc_mod256(regs[i]);
        else if (ld_sel[i]) regs[i] <= BUS_IN;
      end
    end
  end

  assign out_next = inc_sel[OUT_IDX] ? inc_mod256(regs[OUT_IDX]) : BUS_IN;
  assign push     = inc_sel[OUT_IDX] | ld_sel[OUT_IDX];
  assign pop      = (cnt != 2'd0) & OUT_READY;
  assign drop     = push & ~pop & (cnt == 2'd2);

  // q0 is the head; a pop shifts q1 forward, and a simultaneous push lands behind it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= 2'd0;
      q0  <= 8'h00;
      q1  <= 8'h00;
    end else if (pop) begin
      if (push) begin
        if (cnt == 2'd1) begin
          q0 <= out_next;
        end else begin
          q0 <= q1;
          q1 <= out_next;
        end
      end else begin
        q0  <= q1;
        cnt <= cnt - 2'd1;
      end
    end else if (push) begin
      if (cnt == 2'd0) begin
        q0  <= out_next;
        cnt <= 2'd1;
      end else if (cnt == 2'd1) begin
        q1  <= out_next;
        cnt <= 2'd2;
      end
    end
  end

  // A fresh error outranks a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      BUS_CONFLICT <= 1'b0;
      OUT_OVF      <= 1'b0;
    end else begin
      if (conflict_now) BUS_CONFLICT <= 1'b1;
      else if (ERR_CLR) BUS_CONFLICT <= 1'b0;
      if (drop)         OUT_OVF <= 1'b1;
      else if (ERR_CLR) OUT_OVF <= 1'b0;
    end
  end

  assign A_VAL     = regs[0];
  assign B_VAL     = regs[1];
  assign OUT_VALID = (cnt != 2'd0);
  assign OUT_DATA  = OUT_VALID ? q0 : 8'h00;

endmodule

// File: tb/tb_bat_amateur_regfile.sv
// Bench for bat_amateur_regfile: directed and random stimulus checked every cycle against
// an array/queue model of the register file, plus literal expectations on the key scenarios.
module tb_bat_amateur_regfile;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] REGS_INC, REGS_RW, REGS_EN, BUS_IN;
  logic [7:0] BUS_OUT;
  logic       BUS_DRIVE;
  logic [7:0] A_VAL, B_VAL, OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY, ERR_CLR;
  logic       BUS_CONFLICT, OUT_OVF;

  int errors = 0;
  int checks = 0;
  bit stim_done = 1'b0;

  logic [7:0] m_regs [8];
  logic [7:0] m_q [$];
  bit         m_bc, m_ovf;

  bat_amateur_regfile dut (
    .CLK(CLK), .RST(RST), .REGS_INC(REGS_INC), .REGS_RW(REGS_RW), .REGS_EN(REGS_EN),
    .BUS_IN(BUS_IN), .BUS_OUT(BUS_OUT), .BUS_DRIVE(BUS_DRIVE), .A_VAL(A_VAL), .B_VAL(B_VAL),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ERR_CLR(ERR_CLR),
    .BUS_CONFLICT(BUS_CONFLICT), .OUT_OVF(OUT_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of controls on the falling edge; literal checks follow 1 time unit later.
  task automatic step(input logic rst, input logic [7:0] en, input logic [7:0] inc,
                      input logic [7:0] rw, input logic [7:0] bus, input logic rdy,
                      input logic clr);
    @(negedge CLK);
    RST = rst; REGS_EN = en; REGS_INC = inc; REGS_RW = rw;
    BUS_IN = bus; OUT_READY = rdy; ERR_CLR = clr;
    #1;
  endtask

  task automatic model_edge();
    int  ndrv;
    bit  push, pop;
    int  size_before;
    if (!RST) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_q.delete();
      m_bc = 0;
      m_ovf = 0;
    end else begin
      ndrv = 0;
      for (int i = 0; i < 8; i++)
        if (REGS_EN[i] && !REGS_INC[i] && !REGS_RW[i]) ndrv++;
      for (int i = 0; i < 8; i++)
        if (REGS_EN[i]) begin
          if (REGS_INC[i])     m_regs[i] = (m_regs[i] + 1) % 256;
          else if (REGS_RW[i]) m_regs[i] = BUS_IN;
        end
      push = REGS_EN[7] && (REGS_INC[7] || REGS_RW[7]);
      size_before = m_q.size();
      pop = (size_before > 0) && OUT_READY;
      if (pop) void'(m_q.pop_front());
      if (ndrv >= 2) m_bc = 1;
      else if (ERR_CLR) m_bc = 0;
      if (push && size_before == 2 && !pop) m_ovf = 1;
      else begin
        if (push) m_q.push_back(m_regs[7]);
        if (ERR_CLR) m_ovf = 0;
      end
    end
  endtask

  task automatic compare();
    logic [7:0] e_bus;
    logic       e_drv;
    e_bus = 8'h00;
    e_drv = 1'b0;
    if (RST)
      for (int i = 0; i < 8; i++)
        if (!e_drv && REGS_EN[i] && !REGS_INC[i] && !REGS_RW[i]) begin
          e_drv = 1'b1;
          e_bus = m_regs[i];
        end
    chk("bus_drive", {7'd0, BUS_DRIVE}, {7'd0, e_drv});
    chk("bus_out", BUS_OUT, e_bus);
    chk("a_val", A_VAL, m_regs[0]);
    chk("b_val", B_VAL, m_regs[1]);
    chk("out_valid", {7'd0, OUT_VALID}, {7'd0, m_q.size() > 0});
    chk("out_data", OUT_DATA, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("bus_conflict", {7'd0, BUS_CONFLICT}, {7'd0, m_bc});
    chk("out_ovf", {7'd0, OUT_OVF}, {7'd0, m_ovf});
  endtask

  initial begin
    RST = 1'b0; REGS_EN = 8'h00; REGS_INC = 8'h00; REGS_RW = 8'h00;
    BUS_IN = 8'h00; OUT_READY = 1'b0; ERR_CLR = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_bc = 0; m_ovf = 0;
    fork
      begin : model_proc
        while (!stim_done) begin
          @(posedge CLK);
          model_edge();
        end
      end
      begin : cmp_proc
        while (!stim_done) begin
          @(negedge CLK);
          #2;
          compare();
        end
      end
      begin : stim_proc
        step(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("rst_valid", {7'd0, OUT_VALID}, 8'h00);
        chk("rst_a", A_VAL, 8'h00);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

        // Load A then drive it
        step(1, 8'h01, 8'h00, 8'h01, 8'h5A, 0, 0);
        step(1, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_a_load", A_VAL, 8'h5A);
        chk("lit_a_drive", {7'd0, BUS_DRIVE}, 8'h01);
        chk("lit_a_bus", BUS_OUT, 8'h5A);

        // B wraps on increment, never drives
        step(1, 8'h02, 8'h00, 8'h02, 8'hFF, 0, 0);
        step(1, 8'h02, 8'h02, 8'h00, 8'h00, 0, 0);
        chk("lit_b_ff", B_VAL, 8'hFF);
        chk("lit_inc_nodrive", {7'd0, BUS_DRIVE}, 8'h00);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_b_wrap", B_VAL, 8'h00);

        // Two drivers: lowest index wins, conflict sticky, clear, error-beats-clear
        step(1, 8'h04, 8'h00, 8'h04, 8'h11, 0, 0);
        step(1, 8'h20, 8'h00, 8'h20, 8'h22, 0, 0);
        step(1, 8'h24, 8'h00, 8'h00, 8'hEE, 0, 0);
        chk("lit_conf_bus", BUS_OUT, 8'h11);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_conf_set", {7'd0, BUS_CONFLICT}, 8'h01);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_conf_clr", {7'd0, BUS_CONFLICT}, 8'h00);
        step(1, 8'h24, 8'h00, 8'h00, 8'h00, 0, 1);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_conf_wins", {7'd0, BUS_CONFLICT}, 8'h01);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);

        // Display queue overflow and drain
        step(1, 8'h80, 8'h00, 8'h80, 8'h01, 0, 0);
        step(1, 8'h80, 8'h00, 8'h80, 8'h02, 0, 0);
        step(1, 8'h80, 8'h00, 8'h80, 8'h03, 0, 0);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_q_head", OUT_DATA, 8'h01);
        chk("lit_q_ovf", {7'd0, OUT_OVF}, 8'h01);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_q_hold", OUT_DATA, 8'h01);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        chk("lit_q_pop1", OUT_DATA, 8'h01);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        chk("lit_q_pop2", OUT_DATA, 8'h02);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1);
        chk("lit_q_empty", {7'd0, OUT_VALID}, 8'h00);

        // Push and pop together while full
        step(1, 8'h80, 8'h00, 8'h80, 8'h07, 0, 0);
        step(1, 8'h80, 8'h00, 8'h80, 8'h08, 0, 0);
        step(1, 8'h80, 8'h00, 8'h80, 8'h09, 1, 0);
        chk("lit_pp_head", OUT_DATA, 8'h07);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        chk("lit_pp_08", OUT_DATA, 8'h08);
        chk("lit_pp_noovf", {7'd0, OUT_OVF}, 8'h00);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        chk("lit_pp_09", OUT_DATA, 8'h09);
        step(1, 8'h80, 8'h80, 8'h00, 8'h00, 0, 0);
        chk("lit_pp_done", {7'd0, OUT_VALID}, 8'h00);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        chk("lit_inc_push", OUT_DATA, 8'h0A);

        // Reset mid-operation discards the queue and flags
        step(1, 8'h01, 8'h00, 8'h01, 8'h33, 0, 0);
        step(1, 8'h80, 8'h00, 8'h80, 8'h41, 0, 0);
        step(1, 8'h80, 8'h00, 8'h80, 8'h42, 0, 0);
        step(1, 8'h80, 8'h00, 8'h80, 8'h43, 0, 0);
        step(1, 8'h03, 8'h00, 8'h00, 8'h00, 0, 0);
        step(0, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_rst_nodrive", {7'd0, BUS_DRIVE}, 8'h00);
        chk("lit_rst_pre_a", A_VAL, 8'h33);
        chk("lit_rst_pre_ovf", {7'd0, OUT_OVF}, 8'h01);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("lit_rst_valid", {7'd0, OUT_VALID}, 8'h00);
        chk("lit_rst_a", A_VAL, 8'h00);
        chk("lit_rst_conf", {7'd0, BUS_CONFLICT}, 8'h00);
        chk("lit_rst_ovf", {7'd0, OUT_OVF}, 8'h00);

        // Random traffic checked by the model each cycle
        for (int n = 0; n < 400; n++) begin
          step(($urandom_range(0, 39) != 0),
               8'($urandom), 8'($urandom & $urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        step(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        #3;
        stim_done = 1'b1;
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
